ptb_capture_ctrl: RTL
=====================

// Module: ptb_capture_ctrl
// PURPOSE
//  Sequences one pretrigger_buffer channel: owns its size config and reset, arms on ptb_rdy,
//  accepts hw/sw triggers, streams pre+post+1 buffered samples into the waveform buffer (wvb)
//  with an end-of-event marker, then emits one header word per event.
//  Sits between the per-channel trigger logic and the wvb FIFO.
// PARAMETERS
//  P_DATA_WIDTH      22  width of ptb_out / wvb_din
//  P_PRE_CONF_WIDTH   5  width of pre-trigger size config (max 31)
//  P_POST_CONF_WIDTH 12  width of post-trigger sample count
//  P_LTC_WIDTH       48  local time counter width
//  P_DROP_CNT_WIDTH  16  width of dropped-trigger counter
// PORTS
//  clk              in   1   system clock
//  rst_n            in   1   asynchronous, active-low reset
//  en               in   1   level: 1 = capture enabled
//  pre_conf         in   P_PRE_CONF_WIDTH   requested pre-trigger samples
//  post_conf        in   P_POST_CONF_WIDTH  post-trigger samples
//  ltc              in   P_LTC_WIDTH        free-running local time counter
//  trig_in          in   1   hw trigger level, aligned with the adc sample entering the ptb
//  sw_trig          in   1   single-cycle software trigger
//  ptb_rdy          in   1   ptb filled
//  ptb_data         in   P_DATA_WIDTH  ptb output
//  ptb_rst          out  1   sync reset pulse to ptb
//  ptb_size_config  out  P_PRE_CONF_WIDTH  latched, clipped pre config
//  wvb_afull        in   1   wvb cannot accept a full event
//  wvb_wr_en        out  1   sample write strobe
//  wvb_din          out  P_DATA_WIDTH  {ptb_data[MSB:1], eoe}
//  hdr_wr_en        out  1   header write strobe
//  hdr_data         out  P_LTC_WIDTH+P_POST_CONF_WIDTH+2  {ltc@trig, evt_len-1, src, 1'b0}
//  armed            out  1   state == ARMED
//  drop_cnt         out  P_DROP_CNT_WIDTH  saturating count of dropped triggers
// BEHAVIOUR
//  - Reset (async): all outputs 0, ptb_size_config = 3, state IDLE.
//  - States: IDLE -> CFG (en=1) -> WAIT_RDY -> ARMED -> CAPTURE -> HDR -> ARMED.
//  - CFG (1 cycle): latch pre = max(pre_conf,3), post = post_conf; ptb_rst = 1 for this cycle.
//  - WAIT_RDY: hold until ptb_rdy = 1 (first 2^P_PRE_CONF_WIDTH cycles after ptb_rst), then ARMED.
//  - ARMED: trig = rising edge of trig_in OR sw_trig (sw wins src bit when simultaneous).
//  - ARMED, trig & !wvb_afull: latch ltc, src; enter CAPTURE.
//  - ARMED, trig & wvb_afull: trigger dropped, drop_cnt +1 (saturates at all-ones), stay ARMED.
//  - Timing: trigger seen at cycle T -> wvb_wr_en high T+1 .. T+1+pre+post inclusive (pre+post+1 words).
//    First word is sample T-pre; wvb_din registered from ptb_data of previous cycle.
//  - eoe (wvb_din[0]) = 1 only on the last word; 0 otherwise.
//  - Triggers during CAPTURE/HDR ignored, not counted.
//  - HDR (1 cycle): hdr_wr_en = 1, evt_len-1 = pre+post (P_POST_CONF_WIDTH bits, truncates).
//  - After HDR: en = 1 and pre/post unchanged -> ARMED; config changed -> CFG; en = 0 -> IDLE.
//  - en falling mid-event: event completes (no truncated events), then IDLE.
//  - wvb_afull rising mid-event: ignored; wvb guarantees room for a full event once afull = 0.
//  - pre_conf/post_conf changes take effect only via CFG; ptb_size_config is stable in all
//    other states.
//  - rst_n asserted mid-event: event abandoned, no hdr word; wvb owner flushes.
// STRUCTURE
//  - Include file ptb_ctrl_defs.vh: state encodings, HDR field offsets, MIN_PRE = 3.
//  - Sub-module ptb_trig_sel: trig_in edge detect, sw/hw merge, src bit; 1 register stage,
//    compensated so the T definition above holds.
//  - Remainder (FSM, sample counter, header/drop logic) stays flat in this module.
// TESTING
//  - Reset release, en=1, pre_conf=8 -> one ptb_rst pulse, ptb_size_config=8, armed after ptb_rdy.
//  - pre=8, post=20, trig_in rising at T -> 29 writes from T+1, first = ramp sample T-8,
//    eoe only on write 29, then hdr with ltc@T and evt_len-1=28.
//  - pre_conf=1 -> ptb_size_config=3; 3+post+1 words written.
//  - Trigger with wvb_afull=1 -> no writes, drop_cnt 0 -> 1; 0xFFFF + drop stays 0xFFFF.
//  - Second trig_in edge and sw_trig during CAPTURE -> ignored, exactly one event, drop_cnt unchanged.
//  - en->0 mid-capture -> full event + hdr, then IDLE.
//  - rst_n low mid-capture -> outputs 0 immediately, no hdr.

Source files
------------

// File: rtl/ptb_capture_ctrl_pkg.sv
// Shared definitions for the pretrigger-buffer capture controller: default widths,
// FSM state encodings and header word field layout.
package ptb_capture_ctrl_pkg;

  localparam int unsigned DATA_W  = 22;
  localparam int unsigned PRE_W   = 5;
  localparam int unsigned POST_W  = 12;
  localparam int unsigned LTC_W   = 48;
  localparam int unsigned DROP_W  = 16;

  // Smallest pre-trigger depth the ptb supports; smaller requests are clipped up.
  localparam int unsigned MIN_PRE = 3;

  // Header word layout, LSB first: reserved 0, src, evt_len-1, ltc.
  localparam int unsigned HDR_SRC_BIT = 1;
  localparam int unsigned HDR_LEN_LSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_ARMED    = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_HDR      = 3'd5
  } state_t;

  function automatic int unsigned hdr_ltc_lsb(input int unsigned post_w);
    return HDR_LEN_LSB + post_w;
  endfunction

endpackage

// File: rtl/ptb_trig_sel.sv
// Trigger selection: rising-edge detect on the hw trigger level merged with the sw strobe.
// The edge register holds the previous level so the merged trigger lands in the same cycle as the edge.
module ptb_trig_sel (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  input  logic sw_trig,
  output logic trig_c,
  output logic src_c
);

  logic trig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d <= 1'b0;
    end else begin
      trig_d <= trig_in;
    end
  end

  // Software trigger owns the src bit when both fire together.
  assign trig_c = sw_trig | (trig_in & ~trig_d);
  assign src_c  = sw_trig;

endmodule

// File: rtl/ptb_capture_ctrl.sv
// Per-channel capture sequencer: configures and arms the pretrigger buffer, streams one
// pre+post+1 sample event into the wvb with an end-of-event marker, then writes its header.
module ptb_capture_ctrl
  import ptb_capture_ctrl_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH      = DATA_W,
  parameter int unsigned P_PRE_CONF_WIDTH  = PRE_W,
  parameter int unsigned P_POST_CONF_WIDTH = POST_W,
  parameter int unsigned P_LTC_WIDTH       = LTC_W,
  parameter int unsigned P_DROP_CNT_WIDTH  = DROP_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic [P_PRE_CONF_WIDTH-1:0]              pre_conf,
  input  logic [P_POST_CONF_WIDTH-1:0]             post_conf,
  input  logic [P_LTC_WIDTH-1:0]                   ltc,
  input  logic                                     trig_in,
  input  logic                                     sw_trig,
  input  logic                                     ptb_rdy,
  input  logic [P_DATA_WIDTH-1:0]                  ptb_data,
  output logic                                     ptb_rst,
  output logic [P_PRE_CONF_WIDTH-1:0]              ptb_size_config,
  input  logic                                     wvb_afull,
  output logic                                     wvb_wr_en,
  output logic [P_DATA_WIDTH-1:0]                  wvb_din,
  output logic                                     hdr_wr_en,
  output logic [P_LTC_WIDTH+P_POST_CONF_WIDTH+1:0] hdr_data,
  output logic                                     armed,
  output logic [P_DROP_CNT_WIDTH-1:0]              drop_cnt
);

  localparam int unsigned CNT_W = ((P_PRE_CONF_WIDTH > P_POST_CONF_WIDTH) ?
                                   P_PRE_CONF_WIDTH : P_POST_CONF_WIDTH) + 1;
  localparam int unsigned HDR_W       = P_LTC_WIDTH + P_POST_CONF_WIDTH + 2;
  localparam int unsigned HDR_LTC_LSB = hdr_ltc_lsb(P_POST_CONF_WIDTH);

  state_t                        state;
  logic [P_POST_CONF_WIDTH-1:0]  post_q;
  logic [CNT_W-1:0]              remain;

  logic                          trig_c;
  logic                          src_c;
  logic [P_PRE_CONF_WIDTH-1:0]   pre_clip_c;
  logic                          cfg_same_c;
  logic [CNT_W-1:0]              span_c;
  logic [HDR_W-1:0]              hdr_c;
  logic                          unused_lsb;

  ptb_trig_sel u_trig_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .trig_in (trig_in),
    .sw_trig (sw_trig),
    .trig_c  (trig_c),
    .src_c   (src_c)
  );

  // The ptb lsb is replaced by the end-of-event marker.
  assign unused_lsb = ptb_data[0];

  assign pre_clip_c = (pre_conf < P_PRE_CONF_WIDTH'(MIN_PRE)) ?
                      P_PRE_CONF_WIDTH'(MIN_PRE) : pre_conf;
  assign cfg_same_c = (pre_clip_c == ptb_size_config) && (post_conf == post_q);
  assign span_c     = CNT_W'(ptb_size_config) + CNT_W'(post_q);

  always_comb begin
    hdr_c = '0;
    hdr_c[HDR_SRC_BIT]                         = src_c;
    hdr_c[HDR_LEN_LSB +: P_POST_CONF_WIDTH]    = P_POST_CONF_WIDTH'(span_c);
    hdr_c[HDR_LTC_LSB +: P_LTC_WIDTH]          = ltc;
  end

  // Sequencer; ptb_size_config doubles as the latched pre depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      post_q          <= '0;
      remain          <= '0;
      ptb_rst         <= 1'b0;
      ptb_size_config <= P_PRE_CONF_WIDTH'(MIN_PRE);
      wvb_wr_en       <= 1'b0;
      wvb_din         <= '0;
      hdr_wr_en       <= 1'b0;
      hdr_data        <= '0;
      armed           <= 1'b0;
      drop_cnt        <= '0;
    end else begin
      ptb_rst   <= 1'b0;
      wvb_wr_en <= 1'b0;
      hdr_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state           <= ST_CFG;
            ptb_rst         <= 1'b1;
            ptb_size_config <= pre_clip_c;
            post_q          <= post_conf;
          end
        end
        ST_CFG: begin
          state <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (ptb_rdy) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!en) begin
            state <= ST_IDLE;
            armed <= 1'b0;
          end else if (trig_c) begin
            if (wvb_afull) begin
              if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + P_DROP_CNT_WIDTH'(1);
              end
            end else begin
              // First word is the sample the ptb presents this cycle.
              state     <= ST_CAPTURE;
              armed     <= 1'b0;
              wvb_wr_en <= 1'b1;
              wvb_din   <= {ptb_data[P_DATA_WIDTH-1:1], (span_c == '0)};
              remain    <= span_c;
              hdr_data  <= hdr_c;
            end
          end
        end
        ST_CAPTURE: begin
          if (remain != '0) begin
            wvb_wr_en <= 1'b1;
            wvb_din   <= {ptb_data[P_DATA_WIDTH-1:1], (remain == CNT_W'(1))};
            remain    <= remain - CNT_W'(1);
          end else begin
            state     <= ST_HDR;
            hdr_wr_en <= 1'b1;
          end
        end
        ST_HDR: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (cfg_same_c) begin
            state <= ST_ARMED;
            armed <= 1'b1;
          end else begin
            state           <= ST_CFG;
            ptb_rst         <= 1'b1;
            ptb_size_config <= pre_clip_c;
            post_q          <= post_conf;
          end
        end
        default: begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule
